// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int BYTE_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic arst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; both come out of reset at the line's idle level.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: x OVERSAMPLE, 1 start, BYTE_WIDTH data bits LSB first, 1 stop, no parity.
// OVERSAMPLE must be even and >= 4 so the mid-start sample point is meaningful.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int BYTE_WIDTH = BYTE_WIDTH_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  rx,
    input  logic                  tick,
    output logic [BYTE_WIDTH-1:0] data_out,
    output logic                  rx_done,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int TW  = $clog2(OVERSAMPLE) + 1;
    localparam int BCW = $clog2(BYTE_WIDTH) + 1;

    // Sample points: middle of the start bit, then one full bit period per later sample.
    localparam logic [TW-1:0]  MID_START = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]  MID_BIT   = TW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(BYTE_WIDTH - 1);

    logic rx_s;

    rx_state_t             state,     state_n;
    logic [TW-1:0]         tick_cnt,  tick_cnt_n;
    logic [BCW-1:0]        bit_cnt,   bit_cnt_n;
    logic [BYTE_WIDTH-1:0] shreg,     shreg_n;
    logic [BYTE_WIDTH-1:0] data_out_n;
    logic                  rx_done_n, frame_err_n;

    sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
        .clk    (clk),
        .arst_n (arst_n),
        .d      (rx),
        .q      (rx_s)
    );

    // All state and datapath registers; reset drops any partial frame.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            data_out  <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            tick_cnt  <= tick_cnt_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            data_out  <= data_out_n;
            rx_done   <= rx_done_n;
            frame_err <= frame_err_n;
        end
    end

    // Next-state and datapath update; counters only move on tick, so a dead tick stalls the FSM.
    always_comb begin
        state_n     = state;
        tick_cnt_n  = tick_cnt;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        data_out_n  = data_out;
        rx_done_n   = 1'b0;
        frame_err_n = 1'b0;
        case (state)
            IDLE: begin
                // Falling edge seen; timing starts now, independent of tick phase.
                if (!rx_s) begin
                    state_n    = START;
                    tick_cnt_n = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt == MID_START) begin
                        // Still low at mid start bit: real frame. High: a glitch, drop it silently.
                        if (!rx_s) begin
                            state_n    = DATA;
                            tick_cnt_n = '0;
                            bit_cnt_n  = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt == MID_BIT) begin
                        shreg_n    = {rx_s, shreg[BYTE_WIDTH-1:1]};
                        tick_cnt_n = '0;
                        if (bit_cnt == LAST_BIT) state_n = STOP;
                        else                     bit_cnt_n = bit_cnt + 1'b1;
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tick_cnt == MID_BIT) begin
                        tick_cnt_n = '0;
                        // Stop sampled mid-bit, so IDLE is back in time for an immediate next start.
                        if (rx_s) begin
                            data_out_n = shreg;
                            rx_done_n  = 1'b1;
                            state_n    = IDLE;
                        end else begin
                            frame_err_n = 1'b1;
                            state_n     = BREAK;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
            end
            BREAK: begin
                // A held-low line is not a start bit; wait for it to return high first.
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Status output decoded from the state register.
    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: behavioural UART line driver plus an expected-byte model.
module tb_uart_receiver;

    localparam int CPB = 64;   // clk per bit with tick every 4 clk

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       rx = 1'b1;
    logic       tick = 1'b0;
    logic [7:0] data_out;
    logic       rx_done, frame_err, busy;

    uart_receiver #(.BYTE_WIDTH(8), .OVERSAMPLE(16)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .rx        (rx),
        .tick      (tick),
        .data_out  (data_out),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, done_cnt = 0, ferr_cnt = 0, wide_err = 0, overlap_err = 0;
    int done_cyc = 0, start_cyc = 0;
    bit prev_done = 1'b0, prev_ferr = 1'b0, tick_all = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_last = 8'h00;   // model of data_out: last good byte, 0 after reset

    // Baud x16 enable: every 4th clk, or every clk when tick_all is set.
    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            if (tick_all) tick = 1'b1;
            else begin
                tick = (div == 3);
                div  = (div + 1) % 4;
            end
        end
    end

    // Output monitor: counts pulses, records received bytes, flags wide or overlapping pulses.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rx_done) begin
            done_cnt++;
            done_cyc = cyc;
            got_q.push_back(data_out);
            if (prev_done) wide_err++;
        end
        if (frame_err) begin
            ferr_cnt++;
            if (prev_ferr) wide_err++;
        end
        if (rx_done && frame_err) overlap_err++;
        prev_done = rx_done;
        prev_ferr = frame_err;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural line driver; called at a negedge, returns at a negedge. stop_val=0 leaves rx low.
    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int cpb);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (cpb) @(negedge clk);
        end
        rx = stop_val;
        repeat (cpb) @(negedge clk);
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (done_cnt >= target);
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h want 00", data_out); end
        n_cmp++; if (rx_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", rx_done); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL rst_ferr: got %b want 0", frame_err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        arst_n = 1'b1;
        repeat (8) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post_rst_busy: got %b want 0", busy); end
        n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL post_rst_done: got %0d want 0", done_cnt); end
    endtask

    task automatic test_single_a5();
        int d0, f0, lat;
        bit ok;
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1, CPB);
        wait_done(d0 + 1, 200, ok);
        exp_last = 8'hA5;
        repeat (4) @(negedge clk);
        lat = done_cyc - start_cyc;
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL a5_timeout: got %0d pulses want %0d", done_cnt - d0, 1); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL a5_pulses: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (data_out !== exp_last) begin n_bad++; $display("FAIL a5_data: got %h want %h", data_out, exp_last); end
        n_cmp++; if (lat < 592 || lat > 624) begin n_bad++; $display("FAIL a5_latency: got %0d clk want 592..624", lat); end
        n_cmp++; if (ferr_cnt - f0 !== 0) begin n_bad++; $display("FAIL a5_ferr: got %0d want 0", ferr_cnt - f0); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL a5_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int d0, sz;
        bit ok;
        d0 = done_cnt; sz = got_q.size();
        send_frame(8'h00, 1'b1, CPB);
        send_frame(8'hFF, 1'b1, CPB);
        wait_done(d0 + 2, 200, ok);
        exp_last = 8'hFF;
        n_cmp++; if (done_cnt - d0 !== 2) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 2", done_cnt - d0); end
        if (got_q.size() >= sz + 2) begin
            n_cmp++; if (got_q[sz] !== 8'h00) begin n_bad++; $display("FAIL b2b_first: got %h want 00", got_q[sz]); end
            n_cmp++; if (got_q[sz+1] !== 8'hFF) begin n_bad++; $display("FAIL b2b_second: got %h want ff", got_q[sz+1]); end
        end
        n_cmp++; if (data_out !== exp_last) begin n_bad++; $display("FAIL b2b_data: got %h want %h", data_out, exp_last); end
    endtask

    task automatic test_glitch();
        int d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        repeat (12) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_hi: got %b want 1", busy); end
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_lo: got %b want 0", busy); end
        n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL glitch_done: got %0d want 0", done_cnt - d0); end
        n_cmp++; if (ferr_cnt - f0 !== 0) begin n_bad++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt - f0); end
        n_cmp++; if (data_out !== exp_last) begin n_bad++; $display("FAIL glitch_data: got %h want %h", data_out, exp_last); end
    endtask

    task automatic test_break();
        int d0, f0;
        bit ok;
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, CPB);
        repeat (20 * CPB) @(negedge clk);
        n_cmp++; if (ferr_cnt - f0 !== 1) begin n_bad++; $display("FAIL brk_ferr: got %0d want 1", ferr_cnt - f0); end
        n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL brk_spurious: got %0d want 0", done_cnt - d0); end
        n_cmp++; if (data_out !== exp_last) begin n_bad++; $display("FAIL brk_data_held: got %h want %h", data_out, exp_last); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL brk_busy: got %b want 1", busy); end
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL brk_idle: got %b want 0", busy); end
        send_frame(8'h5A, 1'b1, CPB);
        wait_done(d0 + 1, 200, ok);
        exp_last = 8'h5A;
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL brk_next_pulses: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (data_out !== exp_last) begin n_bad++; $display("FAIL brk_next_data: got %h want %h", data_out, exp_last); end
        n_cmp++; if (ferr_cnt - f0 !== 1) begin n_bad++; $display("FAIL brk_ferr_total: got %0d want 1", ferr_cnt - f0); end
    endtask

    task automatic test_reset_mid();
        int d0, f0;
        bit ok;
        d0 = done_cnt; f0 = ferr_cnt;
        fork
            send_frame(8'h96, 1'b1, CPB);
            begin
                repeat (5 * CPB + CPB / 2) @(negedge clk);
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_pre: got %b want 1", busy); end
                arst_n = 1'b0;
                exp_last = 8'h00;
                #1;
                n_cmp++; if (data_out !== exp_last) begin n_bad++; $display("FAIL rmid_data: got %h want %h", data_out, exp_last); end
                n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
                n_cmp++; if (rx_done !== 1'b0 || frame_err !== 1'b0) begin n_bad++; $display("FAIL rmid_pulses: got %b%b want 00", rx_done, frame_err); end
            end
        join
        arst_n = 1'b1;
        repeat (CPB) @(negedge clk);
        n_cmp++; if (done_cnt - d0 !== 0 || ferr_cnt - f0 !== 0) begin n_bad++; $display("FAIL rmid_no_pulse: got %0d/%0d want 0/0", done_cnt - d0, ferr_cnt - f0); end
        send_frame(8'h96, 1'b1, CPB);
        wait_done(d0 + 1, 200, ok);
        exp_last = 8'h96;
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmid_after_timeout: got %0d pulses want 1", done_cnt - d0); end
        n_cmp++; if (data_out !== exp_last) begin n_bad++; $display("FAIL rmid_after_data: got %h want %h", data_out, exp_last); end
    endtask

    task automatic test_tick_high();
        int d0, f0;
        bit ok;
        d0 = done_cnt; f0 = ferr_cnt;
        tick_all = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h81, 1'b1, 16);
        wait_done(d0 + 1, 100, ok);
        repeat (20) @(negedge clk);
        exp_last = 8'h81;
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL tick_hi_pulses: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (data_out !== exp_last) begin n_bad++; $display("FAIL tick_hi_data: got %h want %h", data_out, exp_last); end
        n_cmp++; if (ferr_cnt - f0 !== 0) begin n_bad++; $display("FAIL tick_hi_ferr: got %0d want 0", ferr_cnt - f0); end
        tick_all = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_random();
        int d0, gap;
        logic [7:0] b;
        bit ok;
        d0 = done_cnt;
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            gap = $urandom_range(0, 2);
            exp_q.push_back(b);
            send_frame(b, 1'b1, CPB);
            repeat (gap * CPB / 2) @(negedge clk);
        end
        wait_done(d0 + 6, 300, ok);
        repeat (4) @(negedge clk);
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rnd_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rnd_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (wide_err !== 0) begin n_bad++; $display("FAIL pulse_width: got %0d wide pulses want 0", wide_err); end
        n_cmp++; if (overlap_err !== 0) begin n_bad++; $display("FAIL pulse_overlap: got %0d want 0", overlap_err); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_glitch();
        test_break();
        test_reset_mid();
        test_tick_high();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
